// File: rtl/svm_decision_stage_if.sv
// rtl/svm_decision_stage_if.sv - beat input / decision output bundle for svm_decision_stage
interface svm_decision_stage_if #(
    parameter int DATA_SIZE  = 32,
    parameter int ACCUM_SIZE = 64
);
    logic                         dot_valid;
    logic signed [ACCUM_SIZE-1:0] dot_in;
    logic signed [DATA_SIZE-1:0]  alpha;
    logic                         last_sv;
    logic signed [DATA_SIZE-1:0]  bias;
    logic                         result_valid;
    logic signed [ACCUM_SIZE-1:0] result;
    logic                         class_out;
    logic [15:0]                  sv_count;
    logic                         busy;

    // Producer side: supplies beats and bias, observes decisions.
    modport master (
        output dot_valid, dot_in, alpha, last_sv, bias,
        input  result_valid, result, class_out, sv_count, busy
    );

    // Decision stage side.
    modport slave (
        input  dot_valid, dot_in, alpha, last_sv, bias,
        output result_valid, result, class_out, sv_count, busy
    );
endinterface

// File: rtl/svm_decision_stage.sv
// rtl/svm_decision_stage.sv - 3-stage SVM kernel/weight/accumulate decision pipeline
module svm_decision_stage #(
    parameter int                           DATA_SIZE  = 32,
    parameter int                           ACCUM_SIZE = 64,
    parameter int                           KERNEL     = 0,
    parameter logic signed [ACCUM_SIZE-1:0] KCONST     = 1
) (
    input  logic                clk,
    input  logic                rst,
    svm_decision_stage_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state;
    logic   busy_q;

    // Stage 1 registers: kernel value plus the beat's side-band.
    logic                         s1_valid;
    logic                         s1_last;
    logic signed [ACCUM_SIZE-1:0] s1_k;
    logic signed [DATA_SIZE-1:0]  s1_alpha;

    // Stage 2 registers: weighted term.
    logic                         s2_valid;
    logic                         s2_last;
    logic signed [ACCUM_SIZE-1:0] s2_prod;

    // Stage 3 accumulator and outputs.
    logic signed [ACCUM_SIZE-1:0] sum;
    logic [15:0]                  count;
    logic signed [ACCUM_SIZE-1:0] result_q;
    logic                         class_q;
    logic [15:0]                  sv_count_q;
    logic                         result_valid_q;

    logic signed [ACCUM_SIZE-1:0] k_shift;
    logic signed [ACCUM_SIZE-1:0] k_next;
    logic signed [ACCUM_SIZE-1:0] prod_next;
    logic signed [ACCUM_SIZE-1:0] term_sum;
    logic signed [ACCUM_SIZE-1:0] final_value;
    logic [15:0]                  count_inc;
    state_t                       state_next;

    // Kernel evaluation; the polynomial square keeps only the low ACCUM_SIZE bits.
    always_comb begin
        k_shift = bus.dot_in + KCONST;
        if (KERNEL == 1) begin
            k_next = k_shift * k_shift;
        end else begin
            k_next = bus.dot_in;
        end
    end

    // Weighting and final-sum arithmetic, all wrapping at ACCUM_SIZE bits.
    always_comb begin
        prod_next   = s1_k * ACCUM_SIZE'(s1_alpha);
        term_sum    = sum + s2_prod;
        final_value = term_sum + ACCUM_SIZE'(bus.bias);
        count_inc   = (count == 16'hFFFF) ? 16'hFFFF : count + 16'd1;
    end

    // Next input-FSM state from the sampled beat; bubbles and stray last_sv do nothing.
    always_comb begin
        state_next = state;
        if (bus.dot_valid) begin
            state_next = bus.last_sv ? IDLE : ACCUM;
        end
    end

    // Input FSM; busy is registered against the next values of state and S1/S2 valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == ACCUM) | bus.dot_valid | s1_valid;
        end
    end

    // Stages 1 and 2: kernel register, then weighted product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_k     <= '0;
            s1_alpha <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
        end else begin
            s1_valid <= bus.dot_valid;
            s1_last  <= bus.dot_valid & bus.last_sv;
            s1_k     <= k_next;
            s1_alpha <= bus.alpha;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_prod  <= prod_next;
        end
    end

    // Stage 3: accumulate terms; on the last term publish the decision and restart from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum            <= '0;
            count          <= '0;
            result_q       <= '0;
            class_q        <= 1'b0;
            sv_count_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    result_q       <= final_value;
                    class_q        <= ~final_value[ACCUM_SIZE-1];
                    sv_count_q     <= count_inc;
                    result_valid_q <= 1'b1;
                    sum            <= '0;
                    count          <= '0;
                end else begin
                    sum   <= term_sum;
                    count <= count_inc;
                end
            end
        end
    end

    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.class_out    = class_q;
    assign bus.sv_count     = sv_count_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_svm_decision_stage.sv
// tb/tb_svm_decision_stage.sv - directed self-checking bench for svm_decision_stage
module tb_svm_decision_stage;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    svm_decision_stage_if #(.DATA_SIZE(32), .ACCUM_SIZE(64)) m_if ();
    svm_decision_stage_if #(.DATA_SIZE(32), .ACCUM_SIZE(64)) p_if ();

    svm_decision_stage #(
        .DATA_SIZE(32), .ACCUM_SIZE(64), .KERNEL(0), .KCONST(64'sd1)
    ) dut_lin (
        .clk(clk), .rst(rst), .bus(m_if.slave)
    );

    svm_decision_stage #(
        .DATA_SIZE(32), .ACCUM_SIZE(64), .KERNEL(1), .KCONST(64'sd1)
    ) dut_poly (
        .clk(clk), .rst(rst), .bus(p_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic beat(input logic signed [63:0] d, input logic signed [31:0] a, input logic l);
        m_if.dot_valid = 1'b1;
        m_if.dot_in    = d;
        m_if.alpha     = a;
        m_if.last_sv   = l;
        @(posedge clk);
        #1;
        m_if.dot_valid = 1'b0;
        m_if.last_sv   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic collect(input int budget, output int n, output int idx0,
                           output logic signed [63:0] r0, output logic signed [63:0] r1,
                           output logic c0, output logic [15:0] s0, output logic [15:0] s1);
        n = 0; idx0 = 0; r0 = '0; r1 = '0; c0 = 1'b0; s0 = '0; s1 = '0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (m_if.result_valid) begin
                if (n == 0) begin
                    idx0 = i; r0 = m_if.result; c0 = m_if.class_out; s0 = m_if.sv_count;
                end else if (n == 1) begin
                    r1 = m_if.result; s1 = m_if.sv_count;
                end
                n++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_if.result_valid, m_if.class_out, m_if.busy} !== 3'b000 || m_if.result !== 64'sd0 || m_if.sv_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_lin: rv/class/busy=%b result=%0d sv_count=%0d required 000/0/0",
                     {m_if.result_valid, m_if.class_out, m_if.busy}, m_if.result, m_if.sv_count);
        end
        n_cmp++;
        if ({p_if.result_valid, p_if.class_out, p_if.busy} !== 3'b000 || p_if.result !== 64'sd0 || p_if.sv_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_poly: rv/class/busy=%b result=%0d sv_count=%0d required 000/0/0",
                     {p_if.result_valid, p_if.class_out, p_if.busy}, p_if.result, p_if.sv_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_linear;
        int n, idx;
        logic signed [63:0] r0, r1;
        logic c0;
        logic [15:0] s0, s1;
        m_if.bias = 32'sd5;
        beat(64'sd42, 32'sd3, 1'b0);
        beat(64'sd10, -32'sd2, 1'b1);
        collect(6, n, idx, r0, r1, c0, s0, s1);
        n_cmp++;
        if (n !== 1 || idx !== 2) begin
            n_err++;
            $display("FAIL linear_pulse: pulses=%0d at cycle %0d, required 1 at cycle 2", n, idx);
        end
        n_cmp++;
        if (r0 !== 64'sd111 || c0 !== 1'b1 || s0 !== 16'd2) begin
            n_err++;
            $display("FAIL linear_value: result=%0d class=%b sv_count=%0d required 111/1/2", r0, c0, s0);
        end
        n_cmp++;
        if (m_if.result !== 64'sd111 || m_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL linear_hold: result=%0d busy=%b required 111/0", m_if.result, m_if.busy);
        end
    endtask

    task automatic test_poly;
        int n, idx;
        logic busy_late;
        logic signed [63:0] r;
        logic c;
        logic [15:0] s;
        n = 0; idx = 0; busy_late = 1'b0; r = '0; c = 1'b0; s = '0;
        p_if.bias      = -32'sd40;
        p_if.dot_valid = 1'b1;
        p_if.dot_in    = 64'sd2;
        p_if.alpha     = 32'sd4;
        p_if.last_sv   = 1'b1;
        @(posedge clk);
        #1;
        p_if.dot_valid = 1'b0;
        p_if.last_sv   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) busy_late = busy_late | p_if.busy;
            if (p_if.result_valid) begin
                if (n == 0) begin
                    idx = i; r = p_if.result; c = p_if.class_out; s = p_if.sv_count;
                end
                n++;
            end
        end
        n_cmp++;
        if (n !== 1 || idx !== 2) begin
            n_err++;
            $display("FAIL poly_pulse: pulses=%0d at cycle %0d, required 1 at cycle 2", n, idx);
        end
        n_cmp++;
        if (r !== -64'sd4 || c !== 1'b0 || s !== 16'd1) begin
            n_err++;
            $display("FAIL poly_value: result=%0d class=%b sv_count=%0d required -4/0/1", r, c, s);
        end
        n_cmp++;
        if (busy_late !== 1'b0) begin
            n_err++;
            $display("FAIL poly_busy_idle: busy seen=%b after pipeline drained, required 0", busy_late);
        end
    endtask

    task automatic test_back_to_back;
        int n, idx;
        logic signed [63:0] r0, r1;
        logic c0;
        logic [15:0] s0, s1;
        m_if.bias = 32'sd0;
        m_if.dot_valid = 1'b1;
        m_if.dot_in    = 64'sd5;
        m_if.alpha     = 32'sd1;
        m_if.last_sv   = 1'b1;
        @(posedge clk);
        #1;
        m_if.dot_in    = 64'sd7;
        @(posedge clk);
        #1;
        m_if.dot_valid = 1'b0;
        m_if.last_sv   = 1'b0;
        collect(6, n, idx, r0, r1, c0, s0, s1);
        n_cmp++;
        if (n !== 2 || idx !== 1) begin
            n_err++;
            $display("FAIL b2b_pulses: pulses=%0d first at cycle %0d, required 2 from cycle 1", n, idx);
        end
        n_cmp++;
        if (r0 !== 64'sd5 || r1 !== 64'sd7 || s0 !== 16'd1 || s1 !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_values: results=%0d,%0d sv_counts=%0d,%0d required 5,7 and 1,1", r0, r1, s0, s1);
        end
    endtask

    task automatic test_bubbles;
        int n, idx;
        logic signed [63:0] r0, r1;
        logic c0;
        logic [15:0] s0, s1;
        m_if.bias = 32'sd0;
        beat(64'sd1, 32'sd1, 1'b0);
        idle(3);
        n_cmp++;
        if (m_if.busy !== 1'b1 || m_if.result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bubble_busy: busy=%b rv=%b mid-vector, required 1/0", m_if.busy, m_if.result_valid);
        end
        beat(64'sd2, 32'sd1, 1'b0);
        m_if.last_sv = 1'b1;
        @(posedge clk);
        #1;
        m_if.last_sv = 1'b0;
        beat(64'sd3, 32'sd1, 1'b1);
        collect(6, n, idx, r0, r1, c0, s0, s1);
        n_cmp++;
        if (n !== 1 || r0 !== 64'sd6 || s0 !== 16'd3) begin
            n_err++;
            $display("FAIL bubble_value: pulses=%0d result=%0d sv_count=%0d required 1/6/3", n, r0, s0);
        end
    endtask

    task automatic test_wrap;
        int n, idx;
        logic signed [63:0] r0, r1;
        logic c0;
        logic [15:0] s0, s1;
        m_if.bias = 32'sd0;
        beat(64'sh4000_0000_0000_0000, 32'sd4, 1'b1);
        collect(5, n, idx, r0, r1, c0, s0, s1);
        n_cmp++;
        if (n !== 1 || r0 !== 64'sd0 || c0 !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_value: pulses=%0d result=%0d class=%b required 1/0/1", n, r0, c0);
        end
    endtask

    task automatic test_reset_mid;
        int n, idx;
        logic signed [63:0] r0, r1;
        logic c0;
        logic [15:0] s0, s1;
        m_if.bias = 32'sd0;
        beat(64'sd1, 32'sd1, 1'b0);
        beat(64'sd2, 32'sd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m_if.busy !== 1'b0 || m_if.result !== 64'sd0 || m_if.sv_count !== 16'd0 || m_if.class_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_clear: busy=%b result=%0d sv_count=%0d class=%b required 0/0/0/0",
                     m_if.busy, m_if.result, m_if.sv_count, m_if.class_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        collect(4, n, idx, r0, r1, c0, s0, s1);
        n_cmp++;
        if (n !== 0) begin
            n_err++;
            $display("FAIL reset_mid_nopulse: pulses=%0d after abort, required 0", n);
        end
        beat(64'sd9, 32'sd1, 1'b1);
        collect(5, n, idx, r0, r1, c0, s0, s1);
        n_cmp++;
        if (n !== 1 || idx !== 2 || r0 !== 64'sd9 || s0 !== 16'd1) begin
            n_err++;
            $display("FAIL reset_mid_new: pulses=%0d cycle=%0d result=%0d sv_count=%0d required 1/2/9/1",
                     n, idx, r0, s0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_if.dot_valid = 1'b0; m_if.dot_in = '0; m_if.alpha = '0; m_if.last_sv = 1'b0; m_if.bias = '0;
        p_if.dot_valid = 1'b0; p_if.dot_in = '0; p_if.alpha = '0; p_if.last_sv = 1'b0; p_if.bias = '0;
        test_reset();
        test_linear();
        test_poly();
        test_back_to_back();
        test_bubbles();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
